// File: rtl/convolutional_layer.sv
// Purpose: FxF all-ones convolution over a raster pixel stream, summed across every input channel.
// Latency: zero cycles; output_data is combinational from the current pixel and the delay-line taps.
// Backpressure: none; clk_en=0 freezes all history and valid, while output_data still follows input_data.
module convolutional_layer #(
  parameter int D_WIDTH     = 8,
  parameter int Q_WIDTH     = 16,
  parameter int D_CHANNELS  = 2,
  parameter int Q_CHANNELS  = 3,
  parameter int FILTER_SIZE = 2,
  parameter int IMAGE_SIZE  = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clk_en,
  input  logic [D_CHANNELS*D_WIDTH-1:0]  input_data,
  output logic [Q_CHANNELS*Q_WIDTH-1:0]  output_data,
  output logic                           valid
);

  // Taps needed to reach the oldest window pixel: (F-1) rows plus (F-1) columns back.
  localparam int DEPTH   = (FILTER_SIZE - 1) * IMAGE_SIZE + (FILTER_SIZE - 1);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int N_TERMS = FILTER_SIZE * FILTER_SIZE * D_CHANNELS;
  // Accumulator is wide enough that the full sum never overflows before truncation.
  localparam int ACC_W   = D_WIDTH + $clog2(N_TERMS) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // taps[ch][d-1] holds the pixel accepted d enabled cycles ago on channel ch.
  logic [D_WIDTH-1:0] taps [D_CHANNELS][DEPTH];
  logic [CNT_W-1:0]   fill_cnt;
  logic [ACC_W-1:0]   win  [D_CHANNELS][FILTER_SIZE*FILTER_SIZE];
  logic [ACC_W-1:0]   acc;
  logic [Q_WIDTH-1:0] result;

  // Shift each channel's delay line by one pixel on every accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < D_CHANNELS; ch++) begin
        for (int d = 0; d < DEPTH; d++) begin
          taps[ch][d] <= '0;
        end
      end
    end else if (clk_en) begin
      for (int ch = 0; ch < D_CHANNELS; ch++) begin
        taps[ch][0] <= input_data[ch*D_WIDTH +: D_WIDTH];
        for (int d = DEPTH - 1; d > 0; d--) begin
          taps[ch][d] <= taps[ch][d-1];
        end
      end
    end
  end

  // Count accepted pixels until every tap holds real data, then saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
    end else if (clk_en && (fill_cnt != DEPTH_C)) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Saturated counter means the window is fully populated; stays high until reset.
  assign valid = (fill_cnt == DEPTH_C);

  // Pick the window samples: offset r*W+c, offset 0 is the live pixel, the rest come from taps.
  // No row-boundary masking, so windows crossing a row end simply use the raw raster history.
  for (genvar ch = 0; ch < D_CHANNELS; ch++) begin : g_ch
    for (genvar r = 0; r < FILTER_SIZE; r++) begin : g_row
      for (genvar c = 0; c < FILTER_SIZE; c++) begin : g_col
        if ((r == 0) && (c == 0)) begin : g_live
          assign win[ch][r*FILTER_SIZE+c] = ACC_W'(input_data[ch*D_WIDTH +: D_WIDTH]);
        end else begin : g_tap
          assign win[ch][r*FILTER_SIZE+c] = ACC_W'(taps[ch][r*IMAGE_SIZE+c-1]);
        end
      end
    end
  end

  // All weights are +1, so the result is a plain unsigned sum of every window sample.
  always_comb begin
    acc = '0;
    for (int ch = 0; ch < D_CHANNELS; ch++) begin
      for (int k = 0; k < FILTER_SIZE*FILTER_SIZE; k++) begin
        acc = acc + win[ch][k];
      end
    end
  end

  // Fit the sum to the output slice width: truncate modulo 2^Q_WIDTH or zero-extend.
  if (Q_WIDTH <= ACC_W) begin : g_trunc
    assign result = acc[Q_WIDTH-1:0];
  end else begin : g_ext
    assign result = {{(Q_WIDTH-ACC_W){1'b0}}, acc};
  end

  // Every output channel carries the same result.
  assign output_data = {Q_CHANNELS{result}};

endmodule

// File: tb/tb_convolutional_layer.sv
module tb_convolutional_layer;

  localparam int W     = 64;
  localparam int F     = 2;
  localparam int DEPTH = (F - 1) * W + (F - 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic [15:0] input_data = '0;
  logic [47:0] output_data;
  logic        valid;
  logic [23:0] output_data_q8;
  logic        valid_q8;

  int total = 0;
  int bad   = 0;

  // History of accepted pixels since the last reset, oldest first.
  int h0[$];
  int h1[$];

  always #5 clk = ~clk;

  convolutional_layer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .input_data  (input_data),
    .output_data (output_data),
    .valid       (valid)
  );

  convolutional_layer #(.Q_WIDTH(8)) dut_q8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .input_data  (input_data),
    .output_data (output_data_q8),
    .valid       (valid_q8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Window sum from the raster history: offset r*W+c means the pixel accepted that many pixels ago.
  function automatic int ref_sum(input int d0, input int d1);
    int s;
    int n;
    int off;
    s = d0 + d1;
    n = h0.size();
    for (int r = 0; r < F; r++) begin
      for (int c = 0; c < F; c++) begin
        off = r * W + c;
        if (off != 0 && off <= n) s += h0[n-off] + h1[n-off];
      end
    end
    return s;
  endfunction

  task automatic check_now(input string tag);
    int s;
    logic [15:0] s16;
    logic [7:0]  s8;
    s   = ref_sum(int'(input_data[7:0]), int'(input_data[15:8]));
    s16 = s[15:0];
    s8  = s[7:0];
    chk({tag, "/out"}, output_data, {3{s16}});
    chk({tag, "/valid"}, valid, (h0.size() >= DEPTH));
    chk({tag, "/out_q8"}, output_data_q8, {3{s8}});
    chk({tag, "/valid_q8"}, valid_q8, (h0.size() >= DEPTH));
  endtask

  // Called at posedge+1; presents a pixel, checks it combinationally, then clocks it.
  task automatic step(input logic en, input logic [7:0] d0, input logic [7:0] d1, input string tag);
    clk_en = en;
    input_data = {d1, d0};
    #2;
    check_now(tag);
    @(posedge clk);
    if (en) begin
      h0.push_back(int'(d0));
      h1.push_back(int'(d1));
    end
    #1;
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset(input logic [7:0] d0, input logic [7:0] d1);
    logic [15:0] s;
    clk_en = 1'b0;
    input_data = {d1, d0};
    s = 16'(d0) + 16'(d1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_out", output_data, {3{s}});
    h0.delete();
    h1.delete();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic int ramp_px(input int k);
    return (k % 256) + ((3 * k) % 256);
  endfunction

  initial begin
    int expv;
    logic [7:0] a;
    logic [7:0] b;

    // Reset state: taps zero, output is the live pixel sum only.
    input_data = 16'h0503;
    #2;
    chk("por_valid", valid, 1'b0);
    chk("por_out", output_data, 48'h0008_0008_0008);
    chk("por_out_q8", output_data_q8, 24'h080808);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp stream with the closed-form expectation alongside the model.
    for (int n = 0; n < 200; n++) begin
      clk_en = 1'b1;
      input_data = {8'((3 * n) % 256), 8'(n % 256)};
      #1;
      if (n >= DEPTH) begin
        expv = ramp_px(n) + ramp_px(n - 1) + ramp_px(n - 64) + ramp_px(n - 65);
        chk("ramp_formula", output_data[15:0], 16'(expv));
      end
      chk("ramp_valid", valid, (n >= DEPTH));
      step(1'b1, 8'(n % 256), 8'((3 * n) % 256), "ramp");
    end

    // Single impulse after reset: it shows up at exactly offsets 0, 1, 64, 65.
    do_reset(8'h11, 8'h22);
    for (int idx = 0; idx < 80; idx++) begin
      a = (idx == 0) ? 8'h01 : 8'h00;
      b = (idx == 0) ? 8'h02 : 8'h00;
      clk_en = 1'b1;
      input_data = {b, a};
      #1;
      chk("fill_slice", output_data[15:0],
          (idx == 0 || idx == 1 || idx == 64 || idx == 65) ? 16'd3 : 16'd0);
      chk("fill_valid", valid, (idx >= DEPTH));
      step(1'b1, a, b, "fill");
    end

    // Saturated input across the full window.
    for (int i = 0; i < 70; i++) step(1'b1, 8'hFF, 8'hFF, "ff");
    clk_en = 1'b1;
    input_data = 16'hFFFF;
    #1;
    chk("ff_out", output_data, 48'h07F8_07F8_07F8);
    chk("ff_out_q8", output_data_q8, 24'hF8F8F8);
    #1;

    // Ten-cycle clk_en gap mid-stream with inputs still wiggling.
    for (int i = 0; i < 100; i++) begin
      step((i < 40 || i >= 50), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "gate");
    end

    // Random data with random enables.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rand");
    end

    // Mid-stream reset after fill, then refill.
    do_reset(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 80; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "refill");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
